// File: rtl/lut_sweep_checker_if.sv
// Bus between the sweep checker and whatever controls it and hosts the DUT.
// The checker takes the slave side; the controller/harness takes the master side.
interface lut_sweep_checker_if #(
    parameter int N_IN = 4
);
    logic                   start;
    logic                   stop_on_fail;
    logic                   abort;
    logic [(1<<N_IN)-1:0]   expected_tt;
    logic                   dut_out;
    logic [N_IN-1:0]        vec;
    logic                   busy;
    logic                   done;
    logic                   pass;
    logic [N_IN:0]          mismatch_count;
    logic [N_IN-1:0]        first_fail_vec;
    logic                   first_fail_valid;

    modport master (
        output start, stop_on_fail, abort, expected_tt, dut_out,
        input  vec, busy, done, pass, mismatch_count, first_fail_vec, first_fail_valid
    );

    modport slave (
        input  start, stop_on_fail, abort, expected_tt, dut_out,
        output vec, busy, done, pass, mismatch_count, first_fail_vec, first_fail_valid
    );
endinterface

// File: rtl/lut_sweep_checker.sv
// Exhaustive truth-table checker: walks every input vector of an N_IN-input
// combinational DUT, holds each for DWELL+1 cycles and compares the sampled output.
module lut_sweep_checker #(
    parameter int N_IN  = 4,
    parameter int DWELL = 2
) (
    input logic                clk,
    input logic                rst,
    lut_sweep_checker_if.slave bus
);
    localparam int NV = 1 << N_IN;
    localparam int CW = (DWELL > 0) ? $clog2(DWELL + 1) : 1;
    localparam logic [CW-1:0] DWELL_MAX = CW'(DWELL);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]      state;
    logic [CW-1:0]   dwell_cnt;
    logic [NV-1:0]   tt_latched;
    logic            stop_latched;
    logic [N_IN-1:0] vec_r;
    logic            pass_r;
    logic [N_IN:0]   count_r;
    logic [N_IN-1:0] ff_vec_r;
    logic            ff_valid_r;

    logic            sample_edge;
    logic            miss;
    logic            last_vec;
    logic [N_IN:0]   count_next;

    assign sample_edge = (state == S_DRIVE) && (dwell_cnt == DWELL_MAX);
    assign miss        = bus.dut_out != tt_latched[vec_r];
    assign last_vec    = (vec_r == {N_IN{1'b1}});
    assign count_next  = count_r + {{N_IN{1'b0}}, miss};

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            dwell_cnt    <= '0;
            tt_latched   <= '0;
            stop_latched <= 1'b0;
            vec_r        <= '0;
            pass_r       <= 1'b0;
            count_r      <= '0;
            ff_vec_r     <= '0;
            ff_valid_r   <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    // DONE accepts start just like IDLE so sweeps can run back to back
                    if (bus.start) begin
                        tt_latched   <= bus.expected_tt;
                        stop_latched <= bus.stop_on_fail;
                        count_r      <= '0;
                        ff_vec_r     <= '0;
                        ff_valid_r   <= 1'b0;
                        pass_r       <= 1'b0;
                        vec_r        <= '0;
                        dwell_cnt    <= '0;
                        state        <= S_DRIVE;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_DRIVE: begin
                    if (bus.abort) begin
                        pass_r <= 1'b0;
                        state  <= S_IDLE;
                    end else if (!sample_edge) begin
                        dwell_cnt <= dwell_cnt + 1'b1;
                    end else begin
                        count_r <= count_next;
                        if (miss && !ff_valid_r) begin
                            ff_vec_r   <= vec_r;
                            ff_valid_r <= 1'b1;
                        end
                        // Termination is decided at the last vector, so vec never wraps
                        if (last_vec || (miss && stop_latched)) begin
                            pass_r <= (count_next == '0);
                            state  <= S_DONE;
                        end else begin
                            vec_r     <= vec_r + 1'b1;
                            dwell_cnt <= '0;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.vec              = vec_r;
    assign bus.busy             = (state == S_DRIVE);
    assign bus.done             = (state == S_DONE);
    assign bus.pass             = pass_r;
    assign bus.mismatch_count   = count_r;
    assign bus.first_fail_vec   = ff_vec_r;
    assign bus.first_fail_valid = ff_valid_r;
endmodule

// File: doc/lut_sweep_checker.md
Name: lut_sweep_checker

Overview:
- Clocked, parametrised hardware version of our exhaustive truth-table test benches.
- Sweeps every input combination of an N_IN-input combinational DUT, holds each vector for a programmable dwell time, and samples the DUT output.
- Compares each sample against an expected truth table and reports pass/fail, the mismatch count and the first failing vector.
- Sits beside a DUT as a self-checking harness, in simulation or on-chip BIST.

Parameters:
- N_IN, 4, number of DUT inputs; sweep covers 2^N_IN vectors, N_IN from 1 to 8.
- DWELL, 2, extra hold cycles per vector before sampling; each vector is held DWELL+1 cycles; DWELL >= 0.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a sweep.
- stop_on_fail  in  1  latched at start; 1 = terminate the sweep at the first mismatch.
- abort  in  1  terminates the sweep without setting done.
- expected_tt  in  2^N_IN  expected DUT output, bit i for vector i; latched at start.
- dut_out  in  1  DUT output, combinational function of vec.
- vec  out  N_IN  vector currently driven to the DUT inputs.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse when a sweep completes or stops on fail.
- pass  out  1  valid when done pulses and held until the next accepted start; 1 = zero mismatches.
- mismatch_count  out  N_IN+1  mismatches in the current or last sweep; saturation is impossible.
- first_fail_vec  out  N_IN  first vector that mismatched.
- first_fail_valid  out  1  first_fail_vec holds a real capture.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high. No async logic.
- Reset values: all outputs 0; FSM in IDLE; dwell counter 0.
- Reset mid-sweep: returns to these values on the next edge, with no done pulse.
- FSM states: IDLE, DRIVE, DONE.
- IDLE:
  - start=1 at an edge: latch expected_tt and stop_on_fail; clear mismatch_count, first_fail_valid, first_fail_vec and pass.
  - Same edge: vec <= 0, dwell counter <= 0, busy <= 1, move to DRIVE.
- DRIVE, dwell counter < DWELL: increment the counter; vec held.
- DRIVE, dwell counter == DWELL (sample edge):
  - Compare dut_out against tt_latched[vec].
  - On mismatch: mismatch_count += 1. If first_fail_valid=0, also capture first_fail_vec <= vec and set first_fail_valid <= 1.
  - If vec == 2^N_IN-1, or (mismatch and stop_on_fail): go to DONE.
  - Otherwise: vec <= vec+1, counter <= 0.
- Exact timing: vec changes only at a sample edge or on start. The first sample edge is DWELL+1 edges after the start edge. A full pass takes 2^N_IN*(DWELL+1) cycles in DRIVE.
- DONE (one cycle):
  - done=1 and busy=0 during this cycle.
  - pass = (mismatch_count==0), registered on entry to DONE.
  - vec holds its last value. Next state is IDLE.
  - start during DONE is accepted exactly as in IDLE, giving back-to-back sweeps.
- start while busy: ignored. No change to the latched table or the counters.
- abort while busy: next edge returns to IDLE with busy=0, done=0, pass=0. mismatch_count and first_fail are kept for debug. abort in IDLE/DONE has no effect.
- abort and a sample edge in the same cycle: abort wins; that sample is discarded.
- rst has priority over abort and start; abort has priority over start.
- Changes on expected_tt or stop_on_fail mid-sweep are ignored.
- Wrap-around: vec never wraps. Termination is decided at vec = 2^N_IN-1.
- DWELL=0: one cycle per vector; every DRIVE edge is a sample edge.

Test Plan (N_IN=4, DWELL=2 unless stated; the bench DUT model is a configurable 4-input function of vec):
- Good DUT: expected_tt=16'hA5C3, DUT computes tt[vec], start pulse.
  - Required: vec steps 0..15, each held 3 cycles; done pulses 48 cycles after the start edge.
  - Required: pass=1, mismatch_count=0, first_fail_valid=0.
- Faulty DUT, bit 6 and bit 11 inverted, stop_on_fail=0.
  - Required: done after 48 cycles, pass=0, mismatch_count=2, first_fail_vec=6, first_fail_valid=1.
- Same faulty DUT, stop_on_fail=1.
  - Required: done pulses the cycle after the vec=6 sample edge (21 cycles after start), mismatch_count=1, first_fail_vec=6, final vec=6.
- abort at vec=9.
  - Required: busy=0 next cycle, no done pulse, pass=0.
  - Required: a new start then gives a clean sweep (mismatch_count restarts at 0).
- rst asserted mid-sweep at vec=3 while start is also high.
  - Required: all outputs 0 and IDLE next cycle; start is ignored.
  - Required: a start pulse during DONE begins a second sweep with vec=0 on the following cycle.
- DWELL=0, N_IN=2, expected_tt=4'b0110, XOR DUT.
  - Required: vec changes every cycle; done 4 cycles after start; pass=1.
